// File: rtl/gate_scheduler.sv
// Gate scheduler: arbitrates entry/exit requests and drives the gate.
// Optional feature: EXIT_PRIORITY_EN (exit always beats entry), else round-robin.
module gate_scheduler #(
  parameter int OPEN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot_in,
  input  logic       is_full,
  output logic       entry_signal,
  output logic       exit_signal,
  output logic [1:0] exit_slot,
  output logic       gate_open,
  output logic       entry_pend,
  output logic       exit_pend,
  output logic       req_drop
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    OPEN,
    CLEAR
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       grant_exit;
  logic       grant_exit_n;
  logic       drop_q;
  logic       ent_elig;
  logic       ext_elig;
  logic       pick_exit;
  logic       ent_clr;
  logic       ext_clr;
  logic       ent_keep;
  logic       ext_keep;

`ifndef EXIT_PRIORITY_EN
  logic       rr_exit;
`endif

  // Eligibility and arbitration between the two pending request types.
  always_comb begin
    ent_elig = entry_pend & ~is_full;
    ext_elig = exit_pend;
`ifdef EXIT_PRIORITY_EN
    pick_exit = ext_elig;
`else
    pick_exit = ext_elig & (~ent_elig | rr_exit);
`endif
  end

  // A request already pending and not being serviced this cycle is kept.
  always_comb begin
    ent_clr  = (state == ISSUE) & ~grant_exit;
    ext_clr  = (state == ISSUE) & grant_exit;
    ent_keep = entry_pend & ~ent_clr;
    ext_keep = exit_pend & ~ext_clr;
  end

  // Next-state, open-window counter and grant selection.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    grant_exit_n = grant_exit;
    unique case (state)
      IDLE: begin
        if (ent_elig | ext_elig) begin
          state_n      = ISSUE;
          grant_exit_n = pick_exit;
        end
      end
      ISSUE: begin
        state_n = OPEN;
        cnt_n   = 8'(OPEN_CYCLES - 1);
      end
      OPEN: begin
        if (cnt == 8'd0) begin
          state_n = CLEAR;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      CLEAR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register, counter and grant latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      grant_exit <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      grant_exit <= grant_exit_n;
    end
  end

`ifndef EXIT_PRIORITY_EN
  // Round-robin pointer flips to the other type after every grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_exit <= 1'b0;
    end else if ((state == IDLE) & (ent_elig | ext_elig)) begin
      rr_exit <= ~pick_exit;
    end
  end
`endif

  // Request latches; a new pulse beats the service clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_pend <= 1'b0;
      exit_pend  <= 1'b0;
      exit_slot  <= 2'b00;
      drop_q     <= 1'b0;
    end else begin
      entry_pend <= entry_req | ent_keep;
      exit_pend  <= exit_req | ext_keep;
      if (exit_req & ~ext_keep) begin
        exit_slot <= exit_slot_in;
      end
      drop_q <= (entry_req & ent_keep) | (exit_req & ext_keep);
    end
  end

  // Command and actuator outputs, forced low while reset is held.
  always_comb begin
    entry_signal = reset & (state == ISSUE) & ~grant_exit;
    exit_signal  = reset & (state == ISSUE) & grant_exit;
    gate_open    = reset & (state == OPEN);
    req_drop     = reset & drop_q;
  end

endmodule

// File: tb/tb_gate_scheduler.sv
// Testbench for gate_scheduler: directed scenarios plus random traffic,
// checked against a cycle-count reference model and a command scoreboard.
module tb_gate_scheduler;

  localparam int OC = 8;
`ifdef EXIT_PRIORITY_EN
  localparam bit EXITPRI = 1'b1;
`else
  localparam bit EXITPRI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [1:0] exit_slot_in = 2'b00;
  logic       is_full = 1'b0;
  logic       entry_signal;
  logic       exit_signal;
  logic [1:0] exit_slot;
  logic       gate_open;
  logic       entry_pend;
  logic       exit_pend;
  logic       req_drop;

  gate_scheduler #(.OPEN_CYCLES(OC)) dut (
    .clk(clk),
    .reset(reset),
    .entry_req(entry_req),
    .exit_req(exit_req),
    .exit_slot_in(exit_slot_in),
    .is_full(is_full),
    .entry_signal(entry_signal),
    .exit_signal(exit_signal),
    .exit_slot(exit_slot),
    .gate_open(gate_open),
    .entry_pend(entry_pend),
    .exit_pend(exit_pend),
    .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       is_exit;
    bit [1:0] slot;
  } cmd_t;

  cmd_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;

  bit       m_ent = 0;
  bit       m_ext = 0;
  bit       m_drop = 0;
  bit       m_ptr_exit = 0;
  bit [1:0] m_slot = 0;
  int       issue = -100;
  bit       issue_exit = 0;
  int       idle_from = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit x,
                      input bit [1:0] s, input bit f);
    bit iss, keep_e, keep_x, ee, ex, pick;
    @(posedge clk);
    #1;
    cyc++;
    reset = r;
    entry_req = e;
    exit_req = x;
    exit_slot_in = s;
    is_full = f;
    if (!r) q.delete();
    @(negedge clk);
    if (!r) begin
      chk("rst_gate", gate_open, 1'b0);
      chk("rst_drop", req_drop, 1'b0);
    end else begin
      chk("gate_open", gate_open,
          (issue >= 0) && (cyc > issue) && (cyc <= issue + OC));
      chk("entry_pend", entry_pend, m_ent);
      chk("exit_pend", exit_pend, m_ext);
      chk("req_drop", req_drop, m_drop);
    end
    if (!r) begin
      m_ent = 0;
      m_ext = 0;
      m_drop = 0;
      m_slot = 0;
      m_ptr_exit = 0;
      issue = -100;
      idle_from = cyc + 1;
    end else begin
      iss = (cyc == issue);
      keep_e = m_ent && !(iss && !issue_exit);
      keep_x = m_ext && !(iss && issue_exit);
      m_drop = (e && keep_e) || (x && keep_x);
      if (cyc >= idle_from) begin
        ee = m_ent && !f;
        ex = m_ext;
        if (ee || ex) begin
          pick = ex && (!ee || EXITPRI || m_ptr_exit);
          issue = cyc + 1;
          issue_exit = pick;
          idle_from = cyc + OC + 3;
          m_ptr_exit = !pick;
          q.push_back('{cyc + 1, pick, m_slot});
        end
      end
      m_ent = e || keep_e;
      m_ext = x || keep_x;
      if (x && !keep_x) m_slot = s;
    end
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) step(1, 0, 0, 2'($urandom_range(0, 3)), f);
  endtask

  initial begin : mon
    cmd_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        nchk++;
        nerr++;
        $display("FAIL missing_cmd cycle %0d got none want exit=%0d at %0d",
                 cyc, q[0].is_exit, q[0].cyc);
        void'(q.pop_front());
      end
      if (entry_signal === 1'b1 && exit_signal === 1'b1) begin
        nchk++;
        nerr++;
        $display("FAIL both_cmds cycle %0d got 11 want one", cyc);
      end
      if (entry_signal === 1'b1 || exit_signal === 1'b1) begin
        nchk++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_cmd cycle %0d got ent=%b ext=%b want none",
                   cyc, entry_signal, exit_signal);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.is_exit != exit_signal ||
              (e.is_exit && e.slot !== exit_slot)) begin
            nerr++;
            $display("FAIL cmd cycle %0d got ext=%b slot=%b want ext=%0d slot=%b at %0d",
                     cyc, exit_signal, exit_slot, e.is_exit, e.slot, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    bit full;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // single entry
    step(1, 1, 0, 0, 0);
    idle(14, 0);
    // exit with slot capture; later slot_in changes are ignored
    step(1, 0, 1, 2'b10, 0);
    step(1, 0, 0, 2'b01, 0);
    idle(12, 0);
    // full lot: exit first, entry waits
    step(1, 1, 0, 0, 1);
    step(1, 0, 1, 2'b11, 1);
    idle(16, 1);
    idle(14, 0);
    // simultaneous requests
    step(1, 1, 1, 2'b01, 0);
    idle(26, 0);
    // duplicate entry is dropped
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    idle(14, 0);
    // reset in OPEN cycle 3 with an exit pending
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 2'b10, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(14, 0);
    // random traffic
    full = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) full = !full;
      step($urandom_range(0, 399) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           2'($urandom_range(0, 3)), full);
    end
    idle(30, 0);
    nchk++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d outstanding want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
